// File: rtl/cycle_run_controller.sv
// Run-length controller and cycle counter: counts cycles while running, then halts
// or wraps at a limit latched at start. Also provides a snapshot register and status pulses.
module cycle_run_controller #(
    parameter int WIDTH     = 11,
    parameter int WRAP_MODE = 0
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             capture_i,
    output logic [WIDTH-1:0] clock_counter_o,
    output logic [WIDTH-1:0] snapshot_o,
    output logic             running_o,
    output logic             done_o,
    output logic             wrap_o,
    output logic             overflow_o,
    output logic [7:0]       wrap_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] snapshot_q, snapshot_d;
    logic [7:0]       wrap_count_q, wrap_count_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            limit_q      <= '0;
            snapshot_q   <= '0;
            wrap_count_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            limit_q      <= limit_d;
            snapshot_q   <= snapshot_d;
            wrap_count_q <= wrap_count_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            wrap_q       <= wrap_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first; a path that left one
        // unassigned would infer a latch.
        state_d      = state_q;
        count_d      = count_q;
        limit_d      = limit_q;
        wrap_count_d = wrap_count_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        wrap_d       = 1'b0;
        snapshot_d   = capture_i ? count_q : snapshot_q;

        if (clear_i) begin
            // Clear outranks capture, so the snapshot ends up zero on a shared edge.
            state_d      = ST_IDLE;
            count_d      = '0;
            snapshot_d   = '0;
            wrap_count_d = '0;
            overflow_d   = 1'b0;
        end else if (stop_i) begin
            state_d = ST_IDLE;
        end else if (start_i) begin
            state_d      = ST_RUN;
            count_d      = '0;
            limit_d      = limit_i;
            wrap_count_d = '0;
            overflow_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (count_q == limit_q) begin
                if (WRAP_MODE != 0) begin
                    count_d    = '0;
                    wrap_d     = 1'b1;
                    overflow_d = 1'b1;
                    if (wrap_count_q != 8'hFF) begin
                        wrap_count_d = wrap_count_q + 8'd1;
                    end
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    assign clock_counter_o = count_q;
    assign snapshot_o      = snapshot_q;
    assign running_o       = (state_q == ST_RUN);
    assign done_o          = done_q;
    assign wrap_o          = wrap_q;
    assign overflow_o      = overflow_q;
    assign wrap_count_o    = wrap_count_q;

endmodule

// File: tb/tb_cycle_run_controller.sv
// Directed bench for cycle_run_controller: a 12-bit HALT instance and an
// 11-bit WRAP instance share clock, reset and control inputs.
module tb_cycle_run_controller;

    logic        clk;
    logic        rst_n;
    logic        start, stop, clear, capture;
    logic [11:0] limit;

    logic [11:0] h_count, h_snap;
    logic        h_running, h_done, h_wrap, h_ovf;
    logic [7:0]  h_wcnt;

    logic [10:0] w_count, w_snap;
    logic        w_running, w_done, w_wrap, w_ovf;
    logic [7:0]  w_wcnt;

    int checks = 0;
    int errors = 0;

    cycle_run_controller #(.WIDTH(12), .WRAP_MODE(0)) u_halt (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop),
        .clear_i(clear), .limit_i(limit), .capture_i(capture),
        .clock_counter_o(h_count), .snapshot_o(h_snap), .running_o(h_running),
        .done_o(h_done), .wrap_o(h_wrap), .overflow_o(h_ovf), .wrap_count_o(h_wcnt)
    );

    cycle_run_controller #(.WIDTH(11), .WRAP_MODE(1)) u_wrap (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop),
        .clear_i(clear), .limit_i(limit[10:0]), .capture_i(capture),
        .clock_counter_o(w_count), .snapshot_o(w_snap), .running_o(w_running),
        .done_o(w_done), .wrap_o(w_wrap), .overflow_o(w_ovf), .wrap_count_o(w_wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] lim);
        start = 1'b1;
        limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; stop = 0; clear = 0; capture = 0; limit = '0;
        #3;
        checks++;
        if ({h_count, h_snap, h_running, h_done, h_wrap, h_ovf, h_wcnt} !== '0) begin
            errors++;
            $display("FAIL reset_halt: got %h expected 0",
                     {h_count, h_snap, h_running, h_done, h_wrap, h_ovf, h_wcnt});
        end
        checks++;
        if ({w_count, w_snap, w_running, w_done, w_wrap, w_ovf, w_wcnt} !== '0) begin
            errors++;
            $display("FAIL reset_wrap: got %h expected 0",
                     {w_count, w_snap, w_running, w_done, w_wrap, w_ovf, w_wcnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_range_halt();
        do_start(12'd4095);
        checks++;
        if (h_running !== 1'b1 || h_count !== 12'd0) begin
            errors++;
            $display("FAIL halt_start: running %b count %0d expected 1 0", h_running, h_count);
        end
        for (int k = 1; k <= 4095; k++) begin
            tick();
            checks++;
            if (h_count !== 12'(k) || h_done !== 1'b0) begin
                errors++;
                $display("FAIL halt_count: got %0d done %b expected %0d done 0", h_count, h_done, k);
            end
        end
        tick();
        checks++;
        if (h_done !== 1'b1 || h_running !== 1'b0 || h_count !== 12'd4095) begin
            errors++;
            $display("FAIL halt_done: done %b running %b count %0d expected 1 0 4095",
                     h_done, h_running, h_count);
        end
        tick();
        checks++;
        if (h_done !== 1'b0 || h_count !== 12'd4095) begin
            errors++;
            $display("FAIL halt_hold: done %b count %0d expected 0 4095", h_done, h_count);
        end
    endtask

    task automatic test_wrap();
        do_start(12'd9);
        for (int e = 1; e <= 34; e++) begin
            tick();
            checks++;
            if (w_wrap !== ((e % 10) == 0)) begin
                errors++;
                $display("FAIL wrap_pulse edge %0d: got %b expected %b", e, w_wrap, (e % 10) == 0);
            end
        end
        checks++;
        if (w_wcnt !== 8'd3 || w_ovf !== 1'b1 || w_count !== 11'd4 || w_running !== 1'b1) begin
            errors++;
            $display("FAIL wrap_status: wcnt %0d ovf %b count %0d running %b expected 3 1 4 1",
                     w_wcnt, w_ovf, w_count, w_running);
        end
        // limit 0 wraps every cycle; restart clears overflow and wrap_count.
        do_start(12'd0);
        checks++;
        if (w_ovf !== 1'b0 || w_wcnt !== 8'd0 || w_count !== 11'd0) begin
            errors++;
            $display("FAIL wrap_restart: ovf %b wcnt %0d count %0d expected 0 0 0", w_ovf, w_wcnt, w_count);
        end
        for (int e = 1; e <= 300; e++) begin
            tick();
            checks++;
            if (w_wrap !== 1'b1 || w_count !== 11'd0) begin
                errors++;
                $display("FAIL wrap_zero edge %0d: wrap %b count %0d expected 1 0", e, w_wrap, w_count);
            end
        end
        checks++;
        if (w_wcnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_saturate: got %0d expected 255", w_wcnt);
        end
        // Full-range wrap: 2047 -> 0 -> 1.
        do_start(12'd2047);
        repeat (2047) tick();
        checks++;
        if (w_count !== 11'd2047 || w_wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full_top: count %0d wrap %b expected 2047 0", w_count, w_wrap);
        end
        tick();
        checks++;
        if (w_count !== 11'd0 || w_wrap !== 1'b1 || w_wcnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_full_zero: count %0d wrap %b wcnt %0d expected 0 1 1", w_count, w_wrap, w_wcnt);
        end
        tick();
        checks++;
        if (w_count !== 11'd1 || w_wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full_one: count %0d wrap %b expected 1 0", w_count, w_wrap);
        end
    endtask

    task automatic test_stop();
        do_start(12'd100);
        repeat (37) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (h_running !== 1'b0 || h_count !== 12'd37) begin
            errors++;
            $display("FAIL stop_idle: running %b count %0d expected 0 37", h_running, h_count);
        end
        tick();
        checks++;
        if (h_count !== 12'd37) begin
            errors++;
            $display("FAIL stop_hold: got %0d expected 37", h_count);
        end
        do_start(12'd100);
        checks++;
        if (h_count !== 12'd0 || h_ovf !== 1'b0 || h_running !== 1'b1) begin
            errors++;
            $display("FAIL stop_restart: count %0d ovf %b running %b expected 0 0 1", h_count, h_ovf, h_running);
        end
    endtask

    task automatic test_capture_clear();
        do_start(12'd1000);
        repeat (500) tick();
        checks++;
        if (h_count !== 12'd500) begin
            errors++;
            $display("FAIL cap_reach: got %0d expected 500", h_count);
        end
        capture = 1'b1;
        clear = 1'b1;
        tick();
        capture = 1'b0;
        clear = 1'b0;
        checks++;
        if (h_snap !== 12'd0 || h_running !== 1'b0 || h_count !== 12'd0) begin
            errors++;
            $display("FAIL cap_clear: snap %0d running %b count %0d expected 0 0 0", h_snap, h_running, h_count);
        end
        do_start(12'd1000);
        repeat (20) tick();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        checks++;
        if (h_snap !== 12'd20 || h_count !== 12'd21) begin
            errors++;
            $display("FAIL cap_alone: snap %0d count %0d expected 20 21", h_snap, h_count);
        end
    endtask

    task automatic test_limit_edges();
        do_start(12'd0);
        checks++;
        if (h_running !== 1'b1 || h_done !== 1'b0 || h_count !== 12'd0) begin
            errors++;
            $display("FAIL lim0_start: running %b done %b count %0d expected 1 0 0", h_running, h_done, h_count);
        end
        tick();
        checks++;
        if (h_done !== 1'b1 || h_running !== 1'b0 || h_count !== 12'd0) begin
            errors++;
            $display("FAIL lim0_done: done %b running %b count %0d expected 1 0 0", h_done, h_running, h_count);
        end
        tick();
        checks++;
        if (h_done !== 1'b0) begin
            errors++;
            $display("FAIL lim0_pulse: done %b expected 0", h_done);
        end
        do_start(12'd10);
        limit = 12'd50;
        repeat (10) tick();
        checks++;
        if (h_count !== 12'd10 || h_done !== 1'b0) begin
            errors++;
            $display("FAIL limchg_pre: count %0d done %b expected 10 0", h_count, h_done);
        end
        tick();
        checks++;
        if (h_done !== 1'b1 || h_count !== 12'd10) begin
            errors++;
            $display("FAIL limchg_done: done %b count %0d expected 1 10", h_done, h_count);
        end
    endtask

    task automatic test_async_reset();
        do_start(12'd1000);
        repeat (123) tick();
        checks++;
        if (h_count !== 12'd123) begin
            errors++;
            $display("FAIL areset_reach: got %0d expected 123", h_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({h_count, h_snap, h_running, h_done, h_ovf, h_wcnt} !== '0) begin
            errors++;
            $display("FAIL areset_halt: got %h expected 0", {h_count, h_snap, h_running, h_done, h_ovf, h_wcnt});
        end
        checks++;
        if ({w_count, w_snap, w_running, w_wrap, w_ovf, w_wcnt} !== '0) begin
            errors++;
            $display("FAIL areset_wrap: got %h expected 0", {w_count, w_snap, w_running, w_wrap, w_ovf, w_wcnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(12'd5);
        repeat (5) tick();
        checks++;
        if (h_done !== 1'b0 || h_count !== 12'd5) begin
            errors++;
            $display("FAIL areset_pre: done %b count %0d expected 0 5", h_done, h_count);
        end
        tick();
        checks++;
        if (h_done !== 1'b1 || h_count !== 12'd5) begin
            errors++;
            $display("FAIL areset_done: done %b count %0d expected 1 5", h_done, h_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_range_halt();
        test_wrap();
        test_stop();
        test_capture_clear();
        test_limit_edges();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
